// File: rtl/command_ring_fetcher_if.sv
// Signal bundle between the command ring fetcher and its neighbours:
// operational registers, PCIe memory-read engine and command executor.
interface command_ring_fetcher_if;
    logic         crcr_wr;
    logic [63:0]  crcr_wdata;
    logic         doorbell;
    logic         crr;
    logic [63:0]  dequeue_ptr;
    logic         mrd_req;
    logic [63:0]  mrd_addr;
    logic [31:0]  mrd_len;
    logic         mrd_done;
    logic [127:0] mrd_data;
    logic         trb_valid;
    logic [127:0] trb_data;
    logic [63:0]  trb_addr;
    logic         trb_ready;
    logic         ring_error;

    // The fetcher itself.
    modport master (
        input  crcr_wr, crcr_wdata, doorbell, mrd_done, mrd_data, trb_ready,
        output crr, dequeue_ptr, mrd_req, mrd_addr, mrd_len,
               trb_valid, trb_data, trb_addr, ring_error
    );

    // Everything around the fetcher.
    modport slave (
        output crcr_wr, crcr_wdata, doorbell, mrd_done, mrd_data, trb_ready,
        input  crr, dequeue_ptr, mrd_req, mrd_addr, mrd_len,
               trb_valid, trb_data, trb_addr, ring_error
    );
endinterface

// File: rtl/command_ring_fetcher.sv
// xHCI command ring consumer: fetches TRBs at the dequeue pointer, follows
// Link TRBs, checks cycle bits against RCS and offers command TRBs downstream.
module command_ring_fetcher #(
    parameter int LINK_CHAIN_LIMIT = 4
) (
    input  logic                   clk_pcie,
    input  logic                   rst,
    command_ring_fetcher_if.master bus
);
    localparam int         CNT_W         = $clog2(LINK_CHAIN_LIMIT + 1);
    localparam logic [5:0] TRB_TYPE_LINK = 6'd6;

    typedef enum logic [2:0] {
        IDLE,
        FETCH_REQ,
        FETCH_WAIT,
        DECODE,
        ISSUE,
        ERROR
    } state_t;

    state_t       state_q, state_d;
    logic [63:0]  dequeue_ptr_q, dequeue_ptr_d;
    logic         rcs_q, rcs_d;
    logic         crr_q, crr_d;
    logic         stop_pending_q, stop_pending_d;
    logic         db_pending_q, db_pending_d;
    logic [CNT_W-1:0] link_cnt_q, link_cnt_d;
    logic [127:0] trb_q, trb_d;
    logic         mrd_req_q, mrd_req_d;
    logic [63:0]  mrd_addr_q, mrd_addr_d;
    logic         ring_error_q, ring_error_d;

    logic             crcr_load;
    logic             stop_req;
    logic             trb_cycle;
    logic [5:0]       trb_type;
    logic [CNT_W-1:0] link_cnt_inc;
    logic             unused_crcr_bits;

    assign crcr_load        = bus.crcr_wr && !crr_q;
    assign stop_req         = bus.crcr_wr && crr_q && (bus.crcr_wdata[2] || bus.crcr_wdata[1]);
    assign trb_cycle        = trb_q[96];
    assign trb_type         = trb_q[111:106];
    assign link_cnt_inc     = link_cnt_q + CNT_W'(1);
    assign unused_crcr_bits = ^bus.crcr_wdata[5:3];

    always_ff @(posedge clk_pcie) begin
        if (rst) begin
            state_q        <= IDLE;
            dequeue_ptr_q  <= '0;
            rcs_q          <= 1'b0;
            crr_q          <= 1'b0;
            stop_pending_q <= 1'b0;
            db_pending_q   <= 1'b0;
            link_cnt_q     <= '0;
            trb_q          <= '0;
            mrd_req_q      <= 1'b0;
            mrd_addr_q     <= '0;
            ring_error_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            dequeue_ptr_q  <= dequeue_ptr_d;
            rcs_q          <= rcs_d;
            crr_q          <= crr_d;
            stop_pending_q <= stop_pending_d;
            db_pending_q   <= db_pending_d;
            link_cnt_q     <= link_cnt_d;
            trb_q          <= trb_d;
            mrd_req_q      <= mrd_req_d;
            mrd_addr_q     <= mrd_addr_d;
            ring_error_q   <= ring_error_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        dequeue_ptr_d  = dequeue_ptr_q;
        rcs_d          = rcs_q;
        crr_d          = crr_q;
        stop_pending_d = stop_pending_q;
        db_pending_d   = db_pending_q;
        link_cnt_d     = link_cnt_q;
        trb_d          = trb_q;
        mrd_req_d      = mrd_req_q;
        mrd_addr_d     = mrd_addr_q;
        ring_error_d   = ring_error_q;

        // A load while stopped starts a fresh ring, so stale stop/doorbell
        // requests from the previous ring are dropped with it.
        if (crcr_load) begin
            dequeue_ptr_d  = {bus.crcr_wdata[63:6], 6'h0};
            rcs_d          = bus.crcr_wdata[0];
            ring_error_d   = 1'b0;
            link_cnt_d     = '0;
            stop_pending_d = 1'b0;
            db_pending_d   = 1'b0;
        end
        if (stop_req) begin
            stop_pending_d = 1'b1;
        end
        if (bus.doorbell && state_q != IDLE && state_q != ERROR) begin
            db_pending_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (stop_pending_q) begin
                    crr_d          = 1'b0;
                    stop_pending_d = 1'b0;
                end else if (bus.doorbell) begin
                    crr_d   = 1'b1;
                    state_d = FETCH_REQ;
                end
            end
            FETCH_REQ: begin
                mrd_req_d  = 1'b1;
                mrd_addr_d = dequeue_ptr_q;
                state_d    = FETCH_WAIT;
            end
            FETCH_WAIT: begin
                if (bus.mrd_done) begin
                    trb_d     = bus.mrd_data;
                    mrd_req_d = 1'b0;
                    state_d   = DECODE;
                end
            end
            DECODE: begin
                // A doorbell landing in this very cycle counts as pending.
                if (trb_cycle != rcs_q) begin
                    db_pending_d = 1'b0;
                    if (stop_pending_q) begin
                        crr_d          = 1'b0;
                        stop_pending_d = 1'b0;
                        state_d        = IDLE;
                    end else if (db_pending_q || bus.doorbell) begin
                        state_d = FETCH_REQ;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (trb_type == TRB_TYPE_LINK) begin
                    dequeue_ptr_d = {trb_q[63:4], 4'h0};
                    if (trb_q[97]) begin
                        rcs_d = ~rcs_q;
                    end
                    link_cnt_d = link_cnt_inc;
                    if (link_cnt_inc == CNT_W'(LINK_CHAIN_LIMIT)) begin
                        crr_d        = 1'b0;
                        ring_error_d = 1'b1;
                        state_d      = ERROR;
                    end else begin
                        state_d = FETCH_REQ;
                    end
                end else begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.trb_ready) begin
                    dequeue_ptr_d = dequeue_ptr_q + 64'h10;
                    link_cnt_d    = '0;
                    if (stop_pending_q) begin
                        crr_d          = 1'b0;
                        stop_pending_d = 1'b0;
                        state_d        = IDLE;
                    end else begin
                        state_d = FETCH_REQ;
                    end
                end
            end
            ERROR: begin
                crr_d = 1'b0;
                if (crcr_load) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.crr         = crr_q;
    assign bus.dequeue_ptr = dequeue_ptr_q;
    assign bus.mrd_req     = mrd_req_q;
    assign bus.mrd_addr    = mrd_addr_q;
    assign bus.mrd_len     = 32'h10;
    assign bus.trb_valid   = (state_q == ISSUE);
    assign bus.trb_data    = trb_q;
    assign bus.trb_addr    = dequeue_ptr_q;
    assign bus.ring_error  = ring_error_q;
endmodule
